dmem_dump_arbiter: RTL and testbench
====================================

Name: dmem_dump_arbiter

Overview:
- Sole owner of the data memory port. Arbitrates between the pipeline MEM stage and an end-of-run dump sequencer.
- Normal run: MEM-stage loads and stores pass straight through.
- On the MEM/WB finish pulse, or on a cycle timeout, it freezes the CPU side, counts the run cycles, and streams every memory word out over a valid/ready port for the simulation harness.

Parameters:
- DEPTH, 512, number of 32-bit words in data memory.
- ADDR_W, 9, word-address width (log2 DEPTH).
- TIMEOUT, 300, run cycles allowed before a forced dump (3000 ns at 10 ns clock).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage requests an access this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid the cycle after the accepted load
- cpu_stall  out  1  freeze the pipeline; CPU side is not serviced
- finish  in  1  MEM/WB last-instruction flag; rising edge is the trigger
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, 1-cycle synchronous latency
- dump_valid  out  1  dump word present
- dump_ready  in  1  consumer accepts the word
- dump_addr  out  ADDR_W  word index of dump_data
- dump_data  out  32  memory word
- dump_done  out  1  sticky: all DEPTH words delivered
- cycle_count  out  32  run cycles counted up to the trigger
- addr_err  out  1  sticky: CPU access out of range
- timeout  out  1  sticky: dump was forced by TIMEOUT

Behaviour:
- Reset (async, rst_n=0): state=RUN; all outputs 0, including cpu_stall, mem_*, dump_*, cycle_count, addr_err and timeout. Dump counter is 0. Reset takes effect immediately, mid-dump included, and abandons the dump.
- States: RUN, DRAIN, READ, HOLD, DONE.
- RUN:
  - mem_en=cpu_req; mem_we=cpu_req&cpu_we; mem_addr=cpu_addr[ADDR_W+1:2]; mem_wdata=cpu_wdata. All combinational, same cycle.
  - Out of range means cpu_addr[31:ADDR_W+2] is nonzero. Such an access gets mem_en=0 and addr_err set on the next edge. A load of that kind returns cpu_rdata=0.
  - cpu_rdata equals mem_rdata in the cycle after an in-range load; it is 0 otherwise.
  - cycle_count increments every cycle in RUN.
  - A finish rising edge is detected with a registered copy of finish; finish held high triggers only once.
  - On trigger, go to DRAIN with cpu_stall=1 from the next cycle. The access presented in the trigger cycle is still performed.
  - If cycle_count reaches TIMEOUT-1 with no trigger, set timeout and go to DRAIN.
  - If finish and timeout occur in the same cycle, finish wins and timeout stays 0.
- DRAIN: one cycle, so that a load issued in the last RUN cycle returns. No mem access in this cycle. Then go to READ with dump counter 0.
- READ: mem_en=1, mem_we=0, mem_addr=counter. Next state HOLD.
- HOLD:
  - Present dump_valid=1, dump_addr=counter, dump_data=the captured mem_rdata.
  - dump_data is registered on entry and stays stable while dump_valid=1 and dump_ready=0.
  - On dump_ready=1: if counter==DEPTH-1, go to DONE; otherwise counter+1 and go to READ.
  - This gives 2 cycles per word at best: DEPTH=512 with ready held high takes 1024 cycles.
- DONE: dump_valid=0, dump_done=1 and cpu_stall=1, held until reset.
- From DRAIN onward: CPU inputs are ignored, cycle_count is frozen, and further finish edges are ignored.

Test Plan:
- Pass-through: store 0xDEADBEEF to byte addr 0x10, then load 0x10 → mem_addr=4, mem_we=1 on the store. On the load, cpu_rdata=0xDEADBEEF one cycle later; cpu_stall=0.
- Out of range: store to byte addr 0x800 → mem_en=0, addr_err=1 next cycle. Memory is unchanged when word 0 is read back.
- Finish and dump: preload word i=i+1, pulse finish at cycle 40, hold dump_ready=1 → cycle_count=40 and cpu_stall=1 from cycle 41. Exactly 512 handshakes occur with dump_addr=0..511 and dump_data=1..512. dump_done rises after word 511.
- Backpressure: drop dump_ready for 5 cycles at word 7 → dump_valid stays 1, and dump_addr=7 / dump_data stay stable. Words 7 and 8 are each delivered once, with no skip and no duplicate.
- Timeout: finish never asserts → timeout=1, cycle_count=299, and the full dump follows.
- Reset mid-dump at word 100 → all outputs 0 and state RUN. A later finish restarts the dump at word 0.

Source files
------------

// File: rtl/dmem_dump_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_dump_arbiter_if
//  Description : Bus bundle for the data-memory dump arbiter. Groups the CPU
//                MEM-stage port, the data-memory port and the dump stream.
//                'master' is the arbiter's view, 'slave' the environment's.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_dump_arbiter_if #(
    parameter int ADDR_W = 9
);
    // CPU (MEM stage) side
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              finish;

    // Data memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Dump stream and run status
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       dump_data;
    logic              dump_done;
    logic [31:0]       cycle_count;
    logic              addr_err;
    logic              timeout;

    // Arbiter view
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, finish,
        output cpu_rdata, cpu_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output dump_valid, dump_addr, dump_data, dump_done,
        input  dump_ready,
        output cycle_count, addr_err, timeout
    );

    // Environment view (CPU, memory and dump consumer)
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, finish,
        input  cpu_rdata, cpu_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  dump_valid, dump_addr, dump_data, dump_done,
        output dump_ready,
        input  cycle_count, addr_err, timeout
    );
endinterface
`default_nettype wire

// File: rtl/dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_dump_arbiter
//  Description : Sole owner of the data-memory port. Passes MEM-stage loads
//                and stores straight through while the program runs; on the
//                finish rising edge (or a run-cycle timeout) it freezes the
//                CPU, records the run length and streams every memory word
//                out over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_dump_arbiter #(
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 300
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    dmem_dump_arbiter_if.master    bus
);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_DRAIN = 3'd1,
        S_READ  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       C_TMO_LAST  = 32'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              finish_q;      // previous finish, for edge detect
    logic              load_q;        // in-range load accepted last cycle
    logic              cpu_stall_q;
    logic              dump_valid_q;
    logic              dump_done_q;
    logic              addr_err_q;
    logic              timeout_q;
    logic              hold_first_q;  // first HOLD cycle: mem_rdata is live
    logic [ADDR_W-1:0] cnt_q;         // dump word counter
    logic [31:0]       cycle_count_q;
    logic [31:0]       dump_data_q;   // captured word for stalled HOLD cycles

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] cnt_d;
    logic [31:0]       cycle_count_d;
    logic              w_in_run;
    logic              w_oor;
    logic              w_cpu_acc;
    logic              w_trigger;
    logic              w_tmo_hit;
    logic              w_unused_addr_lsbs;

    assign cnt_d         = cnt_q + 1'b1;
    assign cycle_count_d = cycle_count_q + 32'd1;

    // The CPU only owns the memory port while running and out of reset;
    // the rst_n term keeps the pass-through outputs at zero during reset.
    assign w_in_run  = rst_n && (state_q == S_RUN);
    assign w_oor     = |bus.cpu_addr[31:ADDR_W+2];
    assign w_cpu_acc = w_in_run && bus.cpu_req && !w_oor;

    // Finish is an edge trigger so a level held high fires only once.
    assign w_trigger = (state_q == S_RUN) && bus.finish && !finish_q;

    // Finish takes priority over a timeout landing in the same cycle.
    assign w_tmo_hit = (state_q == S_RUN) && !w_trigger
                       && (cycle_count_q == C_TMO_LAST);

    // Byte-lane bits of the address are not used by a word memory.
    assign w_unused_addr_lsbs = ^bus.cpu_addr[1:0];

    // ------------------------------------------------------------------
    // Memory port: CPU pass-through in RUN, dump reads in READ
    // ------------------------------------------------------------------
    assign bus.mem_en    = w_cpu_acc || (state_q == S_READ);
    assign bus.mem_we    = w_cpu_acc && bus.cpu_we;
    assign bus.mem_addr  = w_in_run              ? bus.cpu_addr[ADDR_W+1:2] :
                           (state_q == S_READ)   ? cnt_q : '0;
    assign bus.mem_wdata = w_in_run ? bus.cpu_wdata : 32'd0;

    // Load data is only forwarded for an accepted in-range load.
    assign bus.cpu_rdata = load_q ? bus.mem_rdata : 32'd0;
    assign bus.cpu_stall = cpu_stall_q;

    // ------------------------------------------------------------------
    // Dump stream and status
    // ------------------------------------------------------------------
    // On the first HOLD cycle the word is still on mem_rdata; afterwards the
    // captured copy keeps dump_data stable under backpressure.
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_addr   = dump_valid_q ? cnt_q : '0;
    assign bus.dump_data   = !dump_valid_q ? 32'd0 :
                             hold_first_q  ? bus.mem_rdata : dump_data_q;
    assign bus.dump_done   = dump_done_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.timeout     = timeout_q;

    // Main control FSM with its registered outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            finish_q      <= 1'b0;
            load_q        <= 1'b0;
            cpu_stall_q   <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_done_q   <= 1'b0;
            addr_err_q    <= 1'b0;
            timeout_q     <= 1'b0;
            hold_first_q  <= 1'b0;
            cnt_q         <= '0;
            cycle_count_q <= 32'd0;
            dump_data_q   <= 32'd0;
        end else begin
            finish_q <= bus.finish;
            load_q   <= w_cpu_acc && !bus.cpu_we;

            case (state_q)
                S_RUN: begin
                    if (bus.cpu_req && w_oor) begin
                        addr_err_q <= 1'b1;
                    end
                    // The run length freezes at the value seen in the
                    // trigger cycle; it only advances while staying in RUN.
                    if (w_trigger) begin
                        state_q     <= S_DRAIN;
                        cpu_stall_q <= 1'b1;
                    end else if (w_tmo_hit) begin
                        state_q     <= S_DRAIN;
                        cpu_stall_q <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else begin
                        cycle_count_q <= cycle_count_d;
                    end
                end

                // Lets a load issued in the final RUN cycle return.
                S_DRAIN: begin
                    cnt_q   <= '0;
                    state_q <= S_READ;
                end

                S_READ: begin
                    state_q      <= S_HOLD;
                    dump_valid_q <= 1'b1;
                    hold_first_q <= 1'b1;
                end

                S_HOLD: begin
                    hold_first_q <= 1'b0;
                    if (hold_first_q) begin
                        dump_data_q <= bus.mem_rdata;
                    end
                    if (bus.dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (cnt_q == C_LAST_WORD) begin
                            state_q     <= S_DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_DONE;
                end

                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_dump_arbiter
//  Description : Directed self-checking bench for dmem_dump_arbiter with a
//                behavioural 512-word synchronous data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_dump_arbiter;

    localparam int DEPTH   = 512;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 300;

    logic clk;
    logic rst_n;
    logic preload;
    int   n_assert;
    int   n_fail;
    int   cyc;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] mem_rdata_r;

    dmem_dump_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_dump_arbiter #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle read latency; preload writes word i = i+1.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'(i + 1);
            end
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                mem_rdata_r <= mem[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".cpu_stall"},   32'(bus.cpu_stall),  0);
        chk({tag, ".cpu_rdata"},   bus.cpu_rdata,       0);
        chk({tag, ".mem_en"},      32'(bus.mem_en),     0);
        chk({tag, ".mem_we"},      32'(bus.mem_we),     0);
        chk({tag, ".mem_addr"},    32'(bus.mem_addr),   0);
        chk({tag, ".mem_wdata"},   bus.mem_wdata,       0);
        chk({tag, ".dump_valid"},  32'(bus.dump_valid), 0);
        chk({tag, ".dump_addr"},   32'(bus.dump_addr),  0);
        chk({tag, ".dump_data"},   bus.dump_data,       0);
        chk({tag, ".dump_done"},   32'(bus.dump_done),  0);
        chk({tag, ".cycle_count"}, bus.cycle_count,     0);
        chk({tag, ".addr_err"},    32'(bus.addr_err),   0);
        chk({tag, ".timeout"},     32'(bus.timeout),    0);
    endtask

    // Consumes dump words until stop_idx words are seen (cycle-bounded);
    // word k must carry address k and data k+1. Optionally stalls word 7.
    task automatic run_dump(input int stop_idx, input bit do_bp, output int ncyc);
        int idx;
        bit bp_done;
        idx     = 0;
        bp_done = 1'b0;
        ncyc    = 0;
        bus.dump_ready = 1'b1;
        while (idx < stop_idx && ncyc < 3000) begin
            if (do_bp && !bp_done && idx == 7 && bus.dump_valid === 1'b1) begin
                bus.dump_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #3;
                    chk("bp.valid", 32'(bus.dump_valid), 1);
                    chk("bp.addr",  32'(bus.dump_addr),  7);
                    chk("bp.data",  bus.dump_data,       8);
                    tick();
                    ncyc++;
                end
                bus.dump_ready = 1'b1;
                bp_done = 1'b1;
            end
            #3;
            if (bus.dump_valid === 1'b1) begin
                chk("dump.addr", 32'(bus.dump_addr), 32'(idx));
                chk("dump.data", bus.dump_data,      32'(idx + 1));
                if (idx == DEPTH - 1) begin
                    chk("dump.done_before_last", 32'(bus.dump_done), 0);
                end
                idx++;
            end
            tick();
            ncyc++;
        end
        chk("dump.word_count", 32'(idx), 32'(stop_idx));
        if (do_bp) begin
            chk("dump.bp_seen", 32'(bp_done), 1);
        end
    endtask

    initial begin
        int ncyc;
        int t;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;

        // ---------------- Reset with a live CPU request -----------------
        rst_n          = 1'b0;
        preload        = 1'b1;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 32'h10;
        bus.cpu_wdata  = 32'hCAFE_F00D;
        bus.finish     = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        preload = 1'b0;
        tick();
        check_reset_outputs("rst0");

        bus.cpu_req = 1'b0;
        rst_n       = 1'b1;
        cyc         = 0;

        // ---------------- Pass-through ----------------------------------
        // cycle 0: store 0xDEADBEEF to byte 0x10 (word 4)
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
        #3;
        chk("st.mem_en",    32'(bus.mem_en),    1);
        chk("st.mem_we",    32'(bus.mem_we),    1);
        chk("st.mem_addr",  32'(bus.mem_addr),  4);
        chk("st.mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        chk("st.cpu_stall", 32'(bus.cpu_stall), 0);
        tick();
        // cycle 1: load byte 0x10
        bus.cpu_we = 1'b0;
        #3;
        chk("ld.mem_en", 32'(bus.mem_en), 1);
        chk("ld.mem_we", 32'(bus.mem_we), 0);
        tick();
        // cycle 2: load data returns
        bus.cpu_req = 1'b0;
        #3;
        chk("ld.cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // ---------------- Out of range ----------------------------------
        // cycle 3: store to byte 0x800 must be dropped
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h800; bus.cpu_wdata = 32'h1234_5678;
        #3;
        chk("idle.cpu_rdata", bus.cpu_rdata,     0);
        chk("oor.mem_en",     32'(bus.mem_en),   0);
        chk("oor.addr_err0",  32'(bus.addr_err), 0);
        tick();
        // cycle 4: out-of-range load
        bus.cpu_we = 1'b0;
        #3;
        chk("oor.addr_err1", 32'(bus.addr_err), 1);
        tick();
        // cycle 5: OOR load returns zero; issue load of word 0
        bus.cpu_addr = 32'h0;
        #3;
        chk("oor.cpu_rdata", bus.cpu_rdata, 0);
        tick();
        // cycle 6: word 0 unchanged; restore word 4 to 5
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'd5;
        #3;
        chk("oor.word0", bus.cpu_rdata, 1);
        tick();
        // cycle 7
        bus.cpu_req = 1'b0;
        #3;
        chk("run.cycle_count7", bus.cycle_count, 7);
        tick();
        while (cyc < 40) tick();

        // ---------------- Finish at cycle 40 and dump --------------------
        bus.finish = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        #3;
        chk("trig.cpu_stall",   32'(bus.cpu_stall), 0);
        chk("trig.cycle_count", bus.cycle_count,    40);
        tick();
        // DRAIN: CPU ignored, trigger-cycle load still returns
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'hFFFF_FFFF;
        bus.dump_ready = 1'b1;
        #3;
        chk("drain.cpu_stall",   32'(bus.cpu_stall), 1);
        chk("drain.cycle_count", bus.cycle_count,    40);
        chk("drain.cpu_rdata",   bus.cpu_rdata,      5);
        chk("drain.mem_en",      32'(bus.mem_en),    0);
        tick();
        // READ of word 0
        bus.cpu_req = 1'b0; bus.finish = 1'b0;
        #3;
        chk("read.mem_en",     32'(bus.mem_en),     1);
        chk("read.mem_we",     32'(bus.mem_we),     0);
        chk("read.mem_addr",   32'(bus.mem_addr),   0);
        chk("read.dump_valid", 32'(bus.dump_valid), 0);
        tick();
        run_dump(DEPTH, 1'b1, ncyc);
        #3;
        chk("done.dump_done",   32'(bus.dump_done),  1);
        chk("done.dump_valid",  32'(bus.dump_valid), 0);
        chk("done.cpu_stall",   32'(bus.cpu_stall),  1);
        chk("done.mem_en",      32'(bus.mem_en),     0);
        chk("done.cycle_count", bus.cycle_count,     40);
        chk("done.timeout",     32'(bus.timeout),    0);
        tick();

        // ---------------- Reset from DONE, then timeout ------------------
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_done");
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        t     = 0;
        while (bus.cpu_stall !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        chk("tmo.stall_cycle", 32'(t),            300);
        chk("tmo.timeout",     32'(bus.timeout),  1);
        chk("tmo.cycle_count", bus.cycle_count,   299);
        run_dump(DEPTH, 1'b0, ncyc);
        chk("tmo.dump_cycles", 32'(ncyc),          1025);
        chk("tmo.dump_done",   32'(bus.dump_done), 1);

        // ---------------- Finish on the timeout cycle, reset mid-dump ---
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 299) tick();
        bus.finish = 1'b1;
        #3;
        chk("tie.cycle_count", bus.cycle_count, 299);
        tick();
        #3;
        chk("tie.cpu_stall",    32'(bus.cpu_stall), 1);
        chk("tie.timeout",      32'(bus.timeout),   0);
        chk("tie.cycle_count2", bus.cycle_count,    299);
        bus.finish = 1'b0;
        tick();
        run_dump(100, 1'b0, ncyc);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        tick(); tick(); tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        #3;
        chk("restart.cycle_count", bus.cycle_count, 3);
        chk("restart.cpu_stall",   32'(bus.cpu_stall), 1);
        tick();
        #3;
        chk("restart.mem_addr", 32'(bus.mem_addr), 0);
        tick();
        run_dump(4, 1'b0, ncyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
